// File: rtl/regfile.sv
// Integer register file x0..x31: sequential storage, two combinational read ports.
// Optional same-cycle wb->id bypass enabled by defining REGFILE_BYPASS_EN.
module regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              stall_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;

  // A write commits only when requested, not stalled, and not targeting x0
  assign w_wr_en = we_i & ~stall_i & (waddr_i != ZERO_IDX);

  // Storage: async clear of every entry, otherwise commit the wb write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Bypass hit: the write committing this cycle targets the read index
  assign w_byp1 = w_wr_en & (waddr_i == raddr1_i);
  assign w_byp2 = w_wr_en & (waddr_i == raddr2_i);

  // Read port 1: reset, disable and x0 force zero; then bypass; then storage
  always_comb begin
    rdata1_o = '0;
    if (rst_n && re1_i && (raddr1_i != ZERO_IDX)) begin
      if (w_byp1) begin
        rdata1_o = wdata_i;
      end else begin
        rdata1_o = r_regs[raddr1_i];
      end
    end
  end

  // Read port 2: same priority as port 1, resolved independently
  always_comb begin
    rdata2_o = '0;
    if (rst_n && re2_i && (raddr2_i != ZERO_IDX)) begin
      if (w_byp2) begin
        rdata2_o = wdata_i;
      end else begin
        rdata2_o = r_regs[raddr2_i];
      end
    end
  end
`else
  // Read port 1: reset, disable and x0 force zero; otherwise stored contents
  always_comb begin
    rdata1_o = '0;
    if (rst_n && re1_i && (raddr1_i != ZERO_IDX)) begin
      rdata1_o = r_regs[raddr1_i];
    end
  end

  // Read port 2: same priority as port 1, resolved independently
  always_comb begin
    rdata2_o = '0;
    if (rst_n && re2_i && (raddr2_i != ZERO_IDX)) begin
      rdata2_o = r_regs[raddr2_i];
    end
  end
`endif

endmodule
